// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
//   Sits beside the ALU in EX. The hazard unit stalls on busy.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous, active-low reset
//     start        operation request, honoured only in IDLE
//     op[1:0]      00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled with start)
//     a, b         multiplicand/dividend, multiplier/divisor (sampled with start)
//     flush        abort the in-flight operation; wins over start
//     hi_we, lo_we direct write of wdata into HI / LO (IDLE only)
//     wdata        direct-write data
//     busy         registered, high while in RUN or FIX
//     done         registered, one-cycle pulse after HI/LO were updated
//     hi, lo       architectural HI/LO registers
//
//   Handshake: start is accepted at a rising edge where the unit is in IDLE
//   and flush is low. busy rises after that edge. Exactly WIDTH+1 edges later
//   busy falls and done rises for one cycle. A new start may be presented in
//   the done cycle.
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]        cnt;
  logic                 is_div_q;    // latched op[1]
  logic                 neg_q;       // operand signs differ (signed ops only)
  logic                 a_neg_q;     // dividend negative (signed ops only)
  logic                 b_zero_q;    // divisor was zero
  logic [WIDTH-1:0]     a_raw_q;     // original a, returned in HI on divide by zero
  logic [WIDTH-1:0]     b_mag_q;     // |b| or raw b
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0]   acc;

  // Operand conditioning at start
  logic             start_ok;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign start_ok = (state == IDLE) && start && !flush;
  assign a_neg    = op[0] & a[WIDTH-1];
  assign b_neg    = op[0] & b[WIDTH-1];
  // The most-negative value maps onto itself, which is its correct unsigned
  // magnitude, so signed overflow falls out of the magnitude algorithm.
  assign a_abs    = a_neg ? -a : a;
  assign b_abs    = b_neg ? -b : b;

  // One radix-2 step
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag_q} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  // Restoring division: trial-subtract the divisor from {rem, next dividend bit}.
  // A borrow (bit WIDTH set) means the divisor did not fit.
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag_q};
  assign div_next  = div_trial[WIDTH]
                   ? {acc[2*WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign correction and result selection in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = a_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (b_zero_q) begin
        res_hi = a_raw_q;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  // FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (cnt == LAST) state_nxt = FIX;
        FIX:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      a_raw_q  <= '0;
      b_mag_q  <= '0;
      acc      <= '0;
    end else if (start_ok) begin
      cnt      <= '0;
      is_div_q <= op[1];
      neg_q    <= a_neg ^ b_neg;
      a_neg_q  <= a_neg;
      b_zero_q <= (b == '0);
      a_raw_q  <= a;
      b_mag_q  <= b_abs;
      acc      <= {{WIDTH{1'b0}}, a_abs};
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      acc <= is_div_q ? div_next : mul_next;
    end
  end

  // HI/LO and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state == FIX) && !flush;
      if ((state == FIX) && !flush) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if ((state == IDLE) && !flush) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule
